div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle unsigned restoring divider: computes one quotient bit per clock by iterating a single
//   shift/compare/subtract stage. Replaces the fully unrolled combinational stage chain where area
//   matters. Sits between a requester (start/operands) and the consumer (done/quotient/remainder).
// PARAMETERS
//   DIVISOR_BITS   8   width of divisor and remainder
//   DIVIDEND_BITS  16  width of dividend and quotient; equals the number of iterations
// PORTS
//   clk        in   1              single clock, rising edge
//   reset      in   1              synchronous, active-high
//   start      in   1              request; sampled only in IDLE
//   dividend   in   DIVIDEND_BITS  unsigned, captured when start is accepted
//   divisor    in   DIVISOR_BITS   unsigned, captured when start is accepted
//   busy       out  1              high from the cycle after acceptance through the DONE cycle
//   done       out  1              one-cycle pulse; results valid from this cycle
//   quotient   out  DIVIDEND_BITS  held until the next accepted start
//   remainder  out  DIVISOR_BITS   held until the next accepted start
//   div_by_zero out 1              set with done when the captured divisor==0; held like quotient
// BEHAVIOUR
//   Clock and reset: one clock; reset is synchronous and active-high.
//   Reset: state=IDLE; busy, done, div_by_zero, quotient, remainder, count = 0.
//     Reset mid-operation aborts the operation and produces no done pulse.
//   States:
//     IDLE: start=1 -> capture operands; clear rem_acc, q_acc, div_by_zero; count=DIVIDEND_BITS-1.
//           If divisor==0 -> DONE, else -> RUN.
//     RUN:  one iteration per cycle, dividend bits MSB first (bit index = count):
//           trial = {rem_acc, dvd[count]} (DIVISOR_BITS+1 bits);
//           if trial >= {1'b0, dsr} -> rem_acc = trial - dsr, qbit = 1; else rem_acc = trial[DIVISOR_BITS-1:0], qbit = 0;
//           q_acc = {q_acc[DIVIDEND_BITS-2:0], qbit}.
//           When count==0 -> DONE; otherwise count decrements.
//     DONE: done=1 for exactly one cycle; quotient/remainder/div_by_zero registers load in the same
//           cycle; then -> IDLE.
//   Latency: start accepted at edge k -> busy=1 from cycle k+1 -> DIVIDEND_BITS RUN cycles
//     -> done=1 in cycle k+DIVIDEND_BITS+1 (k+17 at default widths). Divide-by-zero: done in cycle k+1.
//   Throughput: the next start is accepted in the first IDLE cycle after DONE, so the minimum
//     start-to-start period is DIVIDEND_BITS+2 cycles.
//   start in RUN or DONE is ignored (not queued). Operand inputs are don't-care except at acceptance.
//   Divide-by-zero result: quotient = all ones, remainder = dividend[DIVISOR_BITS-1:0], div_by_zero=1.
//   Arithmetic: the trial compare and subtract are DIVISOR_BITS+1 wide; no signed arithmetic anywhere.
//     The remainder is always < divisor.
// STRUCTURE
//   div_pkg: state enum {IDLE, RUN, DONE}; localparam CNT_BITS = $clog2(DIVIDEND_BITS).
//   Sub-module div_step (combinational): inputs rem_in, next_bit, divisor; outputs rem_out, qbit.
//     Contains the trial subtract and select only. This module owns the FSM, counter and registers.
// TESTING
//   1) dividend=100, divisor=7, start at k -> done at k+17, quotient=14, remainder=2, div_by_zero=0.
//   2) dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; divisor=8'hFF -> quotient=257, remainder=0.
//   3) dividend=5, divisor=200 -> quotient=0, remainder=5.
//   4) dividend=1234, divisor=0 -> done at k+1, div_by_zero=1, quotient=16'hFFFF, remainder=8'hD2.
//   5) start pulsed at k+5 with different operands during RUN -> ignored; first result unchanged;
//      restart in the first IDLE cycle -> accepted.
//   6) reset asserted at k+8 during RUN -> next cycle IDLE, all outputs 0, no done pulse;
//      a new start is accepted normally afterwards.
//   Scoreboard: 10k random operand pairs against a / and % reference model; check done is a single
//     cycle and busy/done timing holds on every operation.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIVISOR_BITS_DEF  = 8;
    localparam int DIVIDEND_BITS_DEF = 16;
    localparam int CNT_BITS          = $clog2(DIVIDEND_BITS_DEF);

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between a requester (master) and the divider (slave).
interface div_sequencer_if
    import div_pkg::*;
#(
    parameter int DIVIDEND_BITS = DIVIDEND_BITS_DEF,
    parameter int DIVISOR_BITS  = DIVISOR_BITS_DEF
) ();

    logic                     start;
    logic [DIVIDEND_BITS-1:0] dividend;
    logic [DIVISOR_BITS-1:0]  divisor;
    logic                     busy;
    logic                     done;
    logic [DIVIDEND_BITS-1:0] quotient;
    logic [DIVISOR_BITS-1:0]  remainder;
    logic                     div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DIVISOR_BITS = 8
) (
    input  logic [DIVISOR_BITS-1:0] rem_in,
    input  logic                    next_bit,
    input  logic [DIVISOR_BITS-1:0] divisor,
    output logic [DIVISOR_BITS-1:0] rem_out,
    output logic                    qbit
);

    logic [DIVISOR_BITS:0] trial;
    logic [DIVISOR_BITS:0] wide_divisor;

    // rem_in < divisor, so the difference always fits back into DIVISOR_BITS.
    always_comb begin
        trial        = {rem_in, next_bit};
        wide_divisor = {1'b0, divisor};
        qbit         = (trial >= wide_divisor);
        rem_out      = qbit ? DIVISOR_BITS'(trial - wide_divisor)
                            : trial[DIVISOR_BITS-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
module div_sequencer
    import div_pkg::*;
#(
    parameter int DIVISOR_BITS  = DIVISOR_BITS_DEF,
    parameter int DIVIDEND_BITS = DIVIDEND_BITS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    div_sequencer_if.slave bus
);

    localparam int CW = $clog2(DIVIDEND_BITS);

    state_t                   state;
    logic [CW-1:0]            count;
    logic [DIVIDEND_BITS-1:0] dvd;
    logic [DIVISOR_BITS-1:0]  dsr;
    logic [DIVISOR_BITS-1:0]  rem_acc;
    logic [DIVIDEND_BITS-1:0] q_acc;
    logic [DIVISOR_BITS-1:0]  rem_next;
    logic                     qbit;

    logic                     busy_r;
    logic                     done_r;
    logic                     dbz_r;
    logic [DIVIDEND_BITS-1:0] quotient_r;
    logic [DIVISOR_BITS-1:0]  remainder_r;

    div_step #(.DIVISOR_BITS(DIVISOR_BITS)) u_step (
        .rem_in   (rem_acc),
        .next_bit (dvd[count]),
        .divisor  (dsr),
        .rem_out  (rem_next),
        .qbit     (qbit)
    );

    // Results load on the same edge that raises done, so they are valid with the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem_acc     <= '0;
            q_acc       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvd     <= bus.dividend;
                        dsr     <= bus.divisor;
                        rem_acc <= '0;
                        q_acc   <= '0;
                        dbz_r   <= 1'b0;
                        count   <= CW'(DIVIDEND_BITS - 1);
                        busy_r  <= 1'b1;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            done_r      <= 1'b1;
                            dbz_r       <= 1'b1;
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend[DIVISOR_BITS-1:0];
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_next;
                    q_acc   <= {q_acc[DIVIDEND_BITS-2:0], qbit};
                    if (count == '0) begin
                        state       <= DONE;
                        done_r      <= 1'b1;
                        quotient_r  <= {q_acc[DIVIDEND_BITS-2:0], qbit};
                        remainder_r <= rem_next;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;

endmodule
